// File: rtl/riscv_pkg.sv
// Shared bus/fetch definitions: line-fill FSM states, the Sysbus line read tag
// and line geometry constants.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_REQ  = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } line_rd_state_t;

  localparam int SYSBUS_TAG_W = 13;

  // Sysbus tag layout: {read/write, target, transaction id}.
  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam logic [7:0] SYSBUS_TXN_ID = 8'h00;

  localparam logic [SYSBUS_TAG_W-1:0] LINE_READ_TAG = {SYSBUS_READ, SYSBUS_MEMORY, SYSBUS_TXN_ID};

  localparam int LINE_BYTES    = 64;
  localparam int LINE_OFFSET_W = 6;

  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return {addr[63:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_reader_assembler.sv
// line_assembler: register file of BEATS bus beats forming one instruction line.
// Synchronous clear wipes every slot; otherwise one slot is written per enable.
module line_assembler #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  parameter int IDX_W  = 3
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [DATA_W*BEATS-1:0] line
);

  logic [DATA_W-1:0] slots_q [BEATS];
  logic [DATA_W-1:0] slots_d [BEATS];

  always_comb begin
    slots_d = slots_q;
    if (clear) begin
      for (int i = 0; i < BEATS; i++) begin
        slots_d[i] = '0;
      end
    end else if (wr_en) begin
      slots_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    slots_q <= slots_d;
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_pack
    assign line[g*DATA_W +: DATA_W] = slots_q[g];
  end

endmodule

// File: rtl/icache_line_reader.sv
// Line fill engine: arbitrate for the system bus, issue one line read, collect
// BEATS response beats. Optional tag filtering: ICACHE_LINE_READER_TAGCHECK_EN.
module icache_line_reader
  import riscv_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int ADDRESS_WIDTH  = 64,
  parameter int BEATS          = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_enable,
  input  logic [ADDRESS_WIDTH-1:0]         in_phy_addr,
  output logic                             out_ready,
  output logic [BUS_DATA_WIDTH*BEATS-1:0]  out_data,
  output logic                             abtr_reqcyc,
  input  logic                             abtr_grant,
  output logic                             bus_busy,
  output logic                             bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]        bus_req,
  output logic [BUS_TAG_WIDTH-1:0]         bus_reqtag,
  input  logic                             bus_reqack,
  input  logic                             bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]        bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]         bus_resptag,
  output logic                             bus_respack,
  output line_rd_state_t                   dbg_state
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG = BUS_TAG_WIDTH'(LINE_READ_TAG);

  line_rd_state_t         state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                   beat_wr_en;
  logic                   beat_accept;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^in_phy_addr[LINE_OFFSET_W-1:0];

`ifdef ICACHE_LINE_READER_TAGCHECK_EN
  // Only the upper tag fields identify the transaction type; low id bits are ignored.
  assign beat_accept = (bus_resptag[BUS_TAG_WIDTH-1:8] == READ_TAG[BUS_TAG_WIDTH-1:8]);
`else
  logic unused_resptag;
  assign unused_resptag = ^{bus_resptag, READ_TAG};
  assign beat_accept    = 1'b1;
`endif

  // Handshakes: abtr_reqcyc holds until abtr_grant; bus_reqcyc/bus_req/bus_reqtag
  // hold (from registers only) until bus_reqack; each bus_respcyc cycle in RESP is
  // acknowledged combinationally by bus_respack in that same cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_cnt_d  = beat_cnt_q;
    beat_wr_en  = 1'b0;
    out_ready   = 1'b0;
    abtr_reqcyc = 1'b0;
    bus_busy    = 1'b0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_enable) begin
          addr_d  = {in_phy_addr[ADDRESS_WIDTH-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        abtr_reqcyc = 1'b1;
        if (abtr_grant) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_busy   = 1'b1;
        bus_reqcyc = 1'b1;
        bus_req    = BUS_DATA_WIDTH'(addr_q);
        bus_reqtag = READ_TAG;
        if (bus_reqack) begin
          beat_cnt_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        bus_busy = 1'b1;
        if (bus_respcyc) begin
          bus_respack = 1'b1;
          if (beat_accept) begin
            beat_wr_en = 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        out_ready = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign dbg_state = state_q;

  line_assembler #(
    .DATA_W (BUS_DATA_WIDTH),
    .BEATS  (BEATS),
    .IDX_W  (CNT_W)
  ) u_line_assembler (
    .clk     (clk),
    .clear   (reset),
    .wr_en   (beat_wr_en),
    .wr_idx  (beat_cnt_q),
    .wr_data (bus_resp),
    .line    (out_data)
  );

endmodule

// File: tb/tb_icache_line_reader.sv
// Self-checking bench for icache_line_reader: directed fills with a line
// scoreboard, handshake timing and reset-mid-fill checks.
module tb_icache_line_reader;
  import riscv_pkg::*;

  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int AW    = 64;
  localparam int BEATS = 8;
  localparam int LW    = DW * BEATS;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_enable;
  logic [AW-1:0]  in_phy_addr;
  logic           out_ready;
  logic [LW-1:0]  out_data;
  logic           abtr_reqcyc;
  logic           abtr_grant;
  logic           bus_busy;
  logic           bus_reqcyc;
  logic [DW-1:0]  bus_req;
  logic [TW-1:0]  bus_reqtag;
  logic           bus_reqack;
  logic           bus_respcyc;
  logic [DW-1:0]  bus_resp;
  logic [TW-1:0]  bus_resptag;
  logic           bus_respack;
  line_rd_state_t dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_count = 0;
  int ready_cyc = -1;
  logic [LW-1:0] exp_q[$];

  icache_line_reader dut (
    .clk         (clk),
    .reset       (reset),
    .in_enable   (in_enable),
    .in_phy_addr (in_phy_addr),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .abtr_reqcyc (abtr_reqcyc),
    .abtr_grant  (abtr_grant),
    .bus_busy    (bus_busy),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter / request counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus_reqcyc && bus_reqack) req_count <= req_count + 1;
  end

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: compare every completed line against the queue head
  always @(negedge clk) begin
    if (!reset && out_ready === 1'b1) begin
      ready_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_ready", 1, 0);
      else check("line", out_data, exp_q.pop_front());
    end
  end

  task automatic idle_inputs();
    in_enable   = 1'b0;
    in_phy_addr = '0;
    abtr_grant  = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = LINE_READ_TAG;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   out_ready,   0);
    check({tag, "_data"},    out_data,    0);
    check({tag, "_arb"},     abtr_reqcyc, 0);
    check({tag, "_busy"},    bus_busy,    0);
    check({tag, "_reqcyc"},  bus_reqcyc,  0);
    check({tag, "_req"},     bus_req,     0);
    check({tag, "_reqtag"},  bus_reqtag,  0);
    check({tag, "_respack"}, bus_respack, 0);
    check({tag, "_state"},   dbg_state,   ST_IDLE);
  endtask

  // One complete fill: gd/ad = grant/reqack delay, gap = idle cycles before each
  // beat, foreign_at = beat index preceded by a foreign-tag beat (tag check build
  // only), reen_at = beat index during which in_enable is pulsed again.
  task automatic do_fill(input logic [AW-1:0] addr, input int gd, input int ad, input int gap,
                         input int foreign_at, input int reen_at, input bit junk_early, input bit rnd);
    logic [DW-1:0] beat [BEATS];
    logic [LW-1:0] line;
    int n, c0, r0, extra;
    extra = 0;
    for (int b = 0; b < BEATS; b++) begin
      beat[b] = rnd ? {$urandom, $urandom} : DW'(b);
      line[b*DW +: DW] = beat[b];
    end
    @(negedge clk);
    r0 = req_count;
    c0 = cyc;
    in_enable   = 1'b1;
    in_phy_addr = addr;
    abtr_grant  = (gd == 0);
    bus_respcyc = junk_early;
    bus_resp    = '1;
    #1 check("idle_respack", bus_respack, 0);
    @(negedge clk);
    in_enable = 1'b0;
    n = 0;
    while (abtr_reqcyc === 1'b1 && n < 100) begin
      n++;
      abtr_grant = (n > gd);
      #1 check("arb_respack", bus_respack, 0);
      check("arb_busy", bus_busy, 0);
      @(negedge clk);
    end
    abtr_grant = 1'b0;
    check("arb_cycles", n, gd + 1);
    n = 0;
    while (bus_reqcyc === 1'b1 && n < 100) begin
      n++;
      check("req_addr", bus_req, line_align(addr));
      check("req_tag", bus_reqtag, LINE_READ_TAG);
      check("req_busy", bus_busy, 1);
      bus_reqack = (n > ad);
      #1 check("req_respack", bus_respack, 0);
      @(negedge clk);
    end
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    check("req_cycles", n, ad + 1);
    check("resp_state", dbg_state, ST_RESP);
    for (int b = 0; b < BEATS; b++) begin
      repeat (gap) begin
        bus_respcyc = 1'b0;
        #1 check("gap_respack", bus_respack, 0);
        @(negedge clk);
      end
`ifdef ICACHE_LINE_READER_TAGCHECK_EN
      if (b == foreign_at) begin
        extra       = 1;
        bus_respcyc = 1'b1;
        bus_resp    = ~beat[b];
        bus_resptag = 13'h00ab;
        #1 check("foreign_respack", bus_respack, 1);
        @(negedge clk);
      end
`endif
      bus_respcyc = 1'b1;
      bus_resp    = beat[b];
      bus_resptag = LINE_READ_TAG;
      if (b == reen_at) in_enable = 1'b1;
      #1 check("beat_respack", bus_respack, 1);
      if (b == BEATS - 1) exp_q.push_back(line);
      @(negedge clk);
      in_enable = 1'b0;
    end
    bus_respcyc = 1'b0;
    #1;
    check("ready_now", out_ready, 1);
    check("latency", ready_cyc - c0 + 1, 12 + gd + ad + BEATS * gap + extra);
    @(negedge clk);
    #1;
    check("ready_pulse", out_ready, 0);
    check("back_idle", dbg_state, ST_IDLE);
    check("one_request", req_count - r0, 1);
    check("data_held", out_data, line);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // directed line: beats 0..7, immediate grant/ack
    do_fill(64'h0000_0000_1000_0024, 0, 0, 0, -1, -1, 1'b0, 1'b0);
    check("first_slot", out_data[63:0], 0);
    check("last_slot", out_data[511:448], 7);

    // delayed grant and reqack
    do_fill({$urandom, $urandom}, 5, 3, 0, -1, -1, 1'b0, 1'b1);
    // gaps between beats
    do_fill({$urandom, $urandom}, 1, 0, 2, -1, -1, 1'b0, 1'b1);
    // in_enable pulsed mid-RESP, stray beats before RESP
    do_fill({$urandom, $urandom}, 2, 1, 0, -1, 3, 1'b1, 1'b1);

    // reset after beat 3 of a fill
    @(negedge clk);
    in_enable   = 1'b1;
    in_phy_addr = 64'h0000_0000_2000_0040;
    abtr_grant  = 1'b1;
    bus_reqack  = 1'b1;
    @(negedge clk);
    in_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      bus_respcyc = 1'b1;
      bus_resp    = {$urandom, $urandom};
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    #1 check_all_zero("midfill_reset");
    idle_inputs();
    reset = 1'b0;
    do_fill({$urandom, $urandom}, 0, 0, 0, -1, -1, 1'b0, 1'b1);

`ifdef ICACHE_LINE_READER_TAGCHECK_EN
    do_fill({$urandom, $urandom}, 0, 0, 0, 4, -1, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 3; i++) begin
      do_fill({$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 1), -1, -1, 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
